fb_scanout: RTL and testbench

Read-side counterpart to the circle plotter. The plotter writes 160x120 3-bit pixels into the framebuffer; this block reads them back.
- Generates 640x480@60 VGA timing from the 50 MHz clock using an internal divide-by-2 pixel enable.
- Reads the framebuffer through a synchronous 1-cycle-latency read port; each stored pixel is replicated 4x horizontally and 4x vertically.
- Drives the DAC pins and exposes vblank/frame_start so drawing FSMs can synchronise to the frame.

---
 rtl/fb_scanout.sv | 171 +++++++++++++++++
 tb/tb_fb_scanout.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: 640x480@60 VGA scan-out of a 160x120 3-bit framebuffer, 4x upscaled.
// The pixel tick is clk/2. The framebuffer is read one pixel tick before the pins show it.
// Optional build macro FB_BORDER_EN: forces colour 3'b111 on the outermost framebuffer
// rows and columns.
module fb_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SCALE_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        fb_rd_en,
  output logic [14:0] fb_rd_addr,
  input  logic [2:0]  fb_rd_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic        vblank,
  output logic        frame_start
);
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic        pix_en;
  logic [9:0]  h_cnt, v_cnt;
  logic        h_last, v_last;
  logic        act, hs_term, vs_term;
  logic [14:0] row15, col15, rd_addr;
  logic [2:0]  pix_c, pix_q;
  logic        s0_act, s0_hs, s0_vs;

  assign h_last  = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last  = (v_cnt == 10'(V_TOTAL - 1));
  assign act     = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign hs_term = ~((h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END)));
  assign vs_term = ~((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END)));
  assign vblank  = (v_cnt >= 10'(V_ACTIVE));
  assign vga_sync_n = 1'b0;

  // Framebuffer address: row*160 + col, with the multiply done as two shifts.
  assign row15   = 15'(v_cnt >> SCALE_LOG2);
  assign col15   = 15'(h_cnt >> SCALE_LOG2);
  assign rd_addr = (row15 << 7) + (row15 << 5) + col15;

`ifdef FB_BORDER_EN
  localparam int unsigned FB_W = H_ACTIVE >> SCALE_LOG2;
  localparam int unsigned FB_H = V_ACTIVE >> SCALE_LOG2;
  logic border, s0_border;

  assign border = (col15 == 15'd0) || (col15 == 15'(FB_W - 1)) ||
                  (row15 == 15'd0) || (row15 == 15'(FB_H - 1));
  assign pix_c  = s0_border ? 3'b111 : fb_rd_data;

  // Border flag travels with the read so it lines up with the returned data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_border <= 1'b0;
    end else if (!en) begin
      s0_border <= 1'b0;
    end else if (pix_en) begin
      s0_border <= border;
    end
  end
`else
  assign pix_c = fb_rd_data;
`endif

  // Divide-by-2 pixel tick; held low while scanning is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en <= 1'b0;
    end else if (!en) begin
      pix_en <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
    end
  end

  // Raster counters: 800 ticks per line, 525 lines per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Read / capture / pin pipeline. Tick edges issue the read and update the pins;
  // the off-tick edge in between captures the returned pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_rd_en    <= 1'b0;
      fb_rd_addr  <= '0;
      pix_q       <= '0;
      s0_act      <= 1'b0;
      s0_hs       <= 1'b1;
      s0_vs       <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_clk     <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      fb_rd_en    <= 1'b0;
      fb_rd_addr  <= '0;
      pix_q       <= '0;
      s0_act      <= 1'b0;
      s0_hs       <= 1'b1;
      s0_vs       <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_clk     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Rises mid-pixel so the DAC samples stable pins.
      vga_clk     <= ~pix_en;
      frame_start <= pix_en & h_last & v_last;
      if (pix_en) begin
        fb_rd_en <= act;
        if (act) begin
          fb_rd_addr <= rd_addr;
        end
        s0_act      <= act;
        s0_hs       <= hs_term;
        s0_vs       <= vs_term;
        vga_r       <= s0_act ? {8{pix_q[2]}} : 8'h00;
        vga_g       <= s0_act ? {8{pix_q[1]}} : 8'h00;
        vga_b       <= s0_act ? {8{pix_q[0]}} : 8'h00;
        vga_hs      <= s0_hs;
        vga_vs      <= s0_vs;
        vga_blank_n <= s0_act;
      end else begin
        fb_rd_en <= 1'b0;
        pix_q    <= pix_c;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed vectors for fb_scanout.
// u_main runs full 640x480 timing against a pattern framebuffer.
// u_small shortens the vertical timing so whole frames fit in a short run.
module tb_fb_scanout;
`ifdef FB_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en_m, en_s, mon_on;

  logic        m_rd_en, m_hs, m_vs, m_bl, m_sync_n, m_vclk, m_vb, m_fs;
  logic [14:0] m_addr;
  logic [2:0]  m_data;
  logic [7:0]  m_r, m_g, m_b;

  logic        s_rd_en, s_hs, s_vs, s_bl, s_sync_n, s_vclk, s_vb, s_fs;
  logic [14:0] s_addr;
  logic [7:0]  s_r, s_g, s_b;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  // Pattern memory: the stored pixel is addr[2:0]^3'b101; garbage when no read is pending.
  assign m_data = m_rd_en ? (m_addr[2:0] ^ 3'b101) : 3'b010;

  fb_scanout u_main (
    .clk(clk), .rst(rst), .en(en_m),
    .fb_rd_en(m_rd_en), .fb_rd_addr(m_addr), .fb_rd_data(m_data),
    .vga_r(m_r), .vga_g(m_g), .vga_b(m_b), .vga_hs(m_hs), .vga_vs(m_vs),
    .vga_blank_n(m_bl), .vga_sync_n(m_sync_n), .vga_clk(m_vclk),
    .vblank(m_vb), .frame_start(m_fs)
  );

  fb_scanout #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_small (
    .clk(clk), .rst(rst), .en(en_s),
    .fb_rd_en(s_rd_en), .fb_rd_addr(s_addr), .fb_rd_data(3'b011),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_blank_n(s_bl), .vga_sync_n(s_sync_n), .vga_clk(s_vclk),
    .vblank(s_vb), .frame_start(s_fs)
  );

  typedef struct {
    int unsigned k;
    logic        rd;
    logic [14:0] addr;
    logic [7:0]  r, g, b;
    logic        hs, bl, vc, bord;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [63:0] pack(logic rd, logic [14:0] a, logic [7:0] r, logic [7:0] g,
                                       logic [7:0] b, logic hs, logic vs, logic bl, logic vc,
                                       logic vb, logic fs);
    return {18'd0, rd, a, r, g, b, hs, vs, bl, vc, vb, fs};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] main_pins(logic chk_addr);
    return pack(m_rd_en, chk_addr ? m_addr : 15'd0, m_r, m_g, m_b, m_hs, m_vs, m_bl, m_vclk,
                m_vb, m_fs);
  endfunction

  // Frame-level measurements on u_small, taken on the falling edge.
  int unsigned scnt = 0;
  int unsigned fs_cnt = 0, fs_first = 0, fs_second = 0;
  int unsigned hs_falls = 0, hs_start = 0, hs_len = 0, hs_period = 0;
  int unsigned vs_start = 0, vs_len = 0, vb_start = 0, vb_len = 0;
  logic        vs_seen = 1'b0, vb_seen = 1'b0;
  logic        s_hs_q = 1'b1, s_vs_q = 1'b1, s_vb_q = 1'b0;
  int unsigned m_fs_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) scnt <= 0;
    else     scnt <= scnt + 1;
  end

  always @(negedge clk) begin
    if (!rst && m_fs) m_fs_cnt <= m_fs_cnt + 1;
    if (!rst && mon_on) begin
      s_hs_q <= s_hs;
      s_vs_q <= s_vs;
      s_vb_q <= s_vb;
      if (s_fs) begin
        fs_cnt <= fs_cnt + 1;
        if (fs_cnt == 0) fs_first <= scnt;
        if (fs_cnt == 1) fs_second <= scnt;
      end
      if (!s_hs && s_hs_q) begin
        hs_falls <= hs_falls + 1;
        hs_start <= scnt;
        if (hs_falls == 1) hs_period <= scnt - hs_start;
      end
      if (s_hs && !s_hs_q && hs_falls == 1 && hs_len == 0) hs_len <= scnt - hs_start;
      if (!s_vs && s_vs_q) begin
        vs_start <= scnt;
        vs_seen  <= 1'b1;
      end
      if (s_vs && !s_vs_q && vs_seen && vs_len == 0) vs_len <= scnt - vs_start;
      if (s_vb && !s_vb_q) begin
        vb_start <= scnt;
        vb_seen  <= 1'b1;
      end
      if (!s_vb && s_vb_q && vb_seen && vb_len == 0) vb_len <= scnt - vb_start;
    end
  end

  initial begin
    int unsigned cur;
    logic [7:0] er, eg, eb;
    logic [7:0] w;

    rst = 1'b1; en_m = 1'b1; en_s = 1'b1; mon_on = 1'b0;

    // k = posedges since reset release; fields: k, rd, addr, r, g, b, hs, blank_n, vga_clk, border
    tbl[0]  = '{1,    1'b0, 15'd0,   8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{2,    1'b1, 15'd0,   8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3,    1'b0, 15'd0,   8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{4,    1'b1, 15'd0,   8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{5,    1'b0, 15'd0,   8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{10,   1'b1, 15'd1,   8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{12,   1'b1, 15'd1,   8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1274, 1'b1, 15'd159, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1282, 1'b0, 15'd0,   8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1284, 1'b0, 15'd0,   8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1315, 1'b0, 15'd0,   8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1316, 1'b0, 15'd0,   8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1507, 1'b0, 15'd0,   8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1508, 1'b0, 15'd0,   8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{6402, 1'b1, 15'd160, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{6404, 1'b1, 15'd160, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{6412, 1'b1, 15'd161, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{7676, 1'b1, 15'd319, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};

    #25;
    check("reset_state", main_pins(1'b1), pack(0, 15'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    check("sync_n_low", {63'd0, m_sync_n}, 64'd0);

    @(negedge clk);
    rst = 1'b0;
    cur = 0;
    for (int i = 0; i < 18; i++) begin
      repeat (tbl[i].k - cur) @(posedge clk);
      cur = tbl[i].k;
      #1;
      er = tbl[i].r; eg = tbl[i].g; eb = tbl[i].b;
      if (BORDER && tbl[i].bord) begin
        er = 8'hFF; eg = 8'hFF; eb = 8'hFF;
      end
      check($sformatf("vec%0d_k%0d", i, tbl[i].k), main_pins(tbl[i].rd),
            pack(tbl[i].rd, tbl[i].rd ? tbl[i].addr : 15'd0, er, eg, eb, tbl[i].hs, 1'b1,
                 tbl[i].bl, tbl[i].vc, 1'b0, 1'b0));
    end

    // Drop enable mid-frame: one clock later everything is idle.
    en_m = 1'b0;
    @(posedge clk); #1;
    check("en_drop_idle", main_pins(1'b0), pack(0, 15'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    repeat (4) @(posedge clk); #1;
    check("en_low_hold", main_pins(1'b1), pack(0, 15'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

    // Restart from (0,0).
    en_m = 1'b1;
    @(posedge clk); #1;
    check("restart_r1", main_pins(1'b0), pack(0, 15'd0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
    @(posedge clk); #1;
    check("restart_first_read", main_pins(1'b1), pack(1, 15'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    repeat (2) @(posedge clk); #1;
    w = BORDER ? 8'hFF : 8'h00;
    check("restart_pix0", main_pins(1'b1), pack(1, 15'd0, 8'hFF, w, 8'hFF, 1, 1, 1, 0, 0, 0));
    repeat (16) @(posedge clk); #1;
    check("restart_r20", main_pins(1'b1), pack(1, 15'd2, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 0, 0, 0));
    @(posedge clk); #1;
    check("restart_r21", main_pins(1'b0), pack(0, 15'd0, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 1, 0, 0));
    check("no_restart_frame_start", 64'(m_fs_cnt), 64'd0);

    // Asynchronous reset between clock edges.
    #3 rst = 1'b1;
    #1;
    check("async_reset", main_pins(1'b1), pack(0, 15'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

    #5;
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (46000) @(posedge clk);
    #1;
    check("frame_start_first", 64'(fs_first), 64'd22400);
    check("frame_start_period", 64'(fs_second - fs_first), 64'd22400);
    check("frame_start_width", 64'(fs_cnt), 64'd2);
    check("hs_low_len", 64'(hs_len), 64'd192);
    check("line_period", 64'(hs_period), 64'd1600);
    check("vs_low_len", 64'(vs_len), 64'd3200);
    check("vblank_len", 64'(vb_len), 64'd9600);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
